// File: rtl/counter_pkg.sv
// Shared types for the counter and its command sequencer.
package counter_pkg;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_UP      = 2'd1,
    OP_DOWN    = 2'd2,
    OP_TO_ZERO = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_LOAD = 3'd1,
    SEQ_STEP = 3'd2,
    SEQ_ZRUN = 3'd3,
    SEQ_DONE = 3'd4
  } seq_state_e;

endpackage

// File: rtl/counter.sv
// Loadable up/down counter with zero and max flags; wraps modulo 2^WIDTH.
module counter #(
  parameter int WIDTH = counter_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic             ce,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data_load,
  output logic [WIDTH-1:0] count_out,
  output logic             zero,
  output logic             max_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_count <= '0;
    else if (!load_n)  r_count <= data_load;
    else if (ce)       r_count <= up_down ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
  end

  assign count_out = r_count;
  assign zero      = (r_count == '0);
  assign max_count = (r_count == '1);

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer driving the counter's control pins from load/count commands.
// Build option COUNTER_SEQ_SAT_EN: stop counting at the rails instead of wrapping.
module counter_cmd_seq
  import counter_pkg::*;
#(
  parameter int WIDTH = counter_pkg::WIDTH,
  parameter int LEN_W = counter_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  cmd_op_e          cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             zero,
  input  logic             max_count,
  output logic             load_n,
  output logic             ce,
  output logic             up_down,
  output logic [WIDTH-1:0] data_load,
  output logic             done,
  output logic             wrap,
  output logic             sat,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE = SEQ_IDLE;
  localparam logic [2:0] S_LOAD = SEQ_LOAD;
  localparam logic [2:0] S_STEP = SEQ_STEP;
  localparam logic [2:0] S_ZRUN = SEQ_ZRUN;
  localparam logic [2:0] S_DONE = SEQ_DONE;

  // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and out of reset, and fields are ignored otherwise.
  logic [2:0]       r_state;
  logic [2:0]       w_next;
  cmd_op_e          r_op;
  logic [LEN_W-1:0] r_rem;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;
  logic             w_up;
  logic             w_sat_hit;

  assign cmd_ready = rst_n && (r_state == S_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_up      = (r_op == OP_UP);

`ifdef COUNTER_SEQ_SAT_EN
  logic r_sat;
  assign w_sat_hit = (r_state == S_STEP) && (w_up ? max_count : zero);
  assign sat       = r_sat;
  assign wrap      = 1'b0;
`else
  assign w_sat_hit = 1'b0;
  assign sat       = 1'b0;
  assign wrap      = ce && (up_down ? max_count : zero);
`endif

  always_comb begin
    ce = 1'b0;
    case (r_state)
      S_STEP:  ce = !w_sat_hit;
      S_ZRUN:  ce = !zero;
      default: ce = 1'b0;
    endcase
  end

  assign up_down   = (r_state == S_STEP) && w_up;
  assign load_n    = (r_state != S_LOAD);
  assign data_load = r_data;
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_LOAD:       w_next = S_LOAD;
            OP_UP, OP_DOWN: w_next = (cmd_len != '0) ? S_STEP : S_DONE;
            OP_TO_ZERO:    w_next = S_ZRUN;
            default:       w_next = S_IDLE;
          endcase
        end
      end
      S_LOAD:  w_next = S_DONE;
      S_STEP:  if (w_sat_hit || r_rem == LEN_W'(1)) w_next = S_DONE;
      S_ZRUN:  if (zero) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_LOAD;
      r_rem   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= cmd_op;
        r_rem <= cmd_len;
        // data_load keeps the last LOAD value so the counter pins stay stable
        if (cmd_op == OP_LOAD) r_data <= cmd_data;
      end else if (r_state == S_STEP) begin
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

`ifdef COUNTER_SEQ_SAT_EN
  // Raised on the edge entering DONE so sat lines up with done
  always_ff @(posedge clk) begin
    if (!rst_n) r_sat <= 1'b0;
    else        r_sat <= w_sat_hit;
  end
`endif

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq driving counter: table of commands, random counts, reset abort.
module tb_counter_cmd_seq;
  import counter_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [3:0]       cmd_data;
  logic [7:0]       cmd_len;
  logic             zero, max_count;
  logic             load_n, ce, up_down;
  logic [3:0]       data_load;
  logic             done, wrap, sat;
  logic [2:0]       dbg_state;
  logic [3:0]       count_out;

  counter_cmd_seq #(.WIDTH(4), .LEN_W(8)) u_seq (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .zero(zero), .max_count(max_count), .load_n(load_n), .ce(ce),
    .up_down(up_down), .data_load(data_load), .done(done), .wrap(wrap),
    .sat(sat), .dbg_state(dbg_state)
  );

  counter #(.WIDTH(4)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load_n(load_n), .ce(ce), .up_down(up_down),
    .data_load(data_load), .count_out(count_out), .zero(zero), .max_count(max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef COUNTER_SEQ_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    int count; int nce; int lat; int nwrap; int nsat; int nld;
  } exp_t;

  typedef struct {
    cmd_op_e    op;
    logic [3:0] data;
    logic [7:0] len;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observe one command from just after its handshake edge until done.
  task automatic wait_done(input string tag, input logic [3:0] data);
    int lat = 0, nce = 0, nwrap = 0, nsat = 0, nld = 0, bad_ld = 0;
    bit got = 0, sat_at_done = 0;
    exp_t e;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ce) nce++;
      if (wrap) nwrap++;
      if (sat) nsat++;
      if (!load_n) begin
        nld++;
        if (data_load !== data) bad_ld++;
      end
      if (done) begin
        got = 1;
        sat_at_done = sat;
      end
    end
    e = exp_q.pop_front();
    chk({tag, " done_seen"}, int'(got), 1);
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " count_out"}, int'(count_out), e.count);
    chk({tag, " ce_cycles"}, nce, e.nce);
    chk({tag, " wrap_pulses"}, nwrap, e.nwrap);
    chk({tag, " sat_pulses"}, nsat, e.nsat);
    if (e.nsat != 0) chk({tag, " sat_with_done"}, int'(sat_at_done), 1);
    chk({tag, " load_cycles"}, nld, e.nld);
    if (e.nld != 0) chk({tag, " load_data"}, bad_ld, 0);
  endtask

  task automatic run_cmd(input string tag, input cmd_op_e op, input logic [3:0] data,
                         input logic [7:0] len, input exp_t e);
    int guard = 0;
    exp_q.push_back(e);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " ready_timeout"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 4'($urandom);
    cmd_len   = 8'($urandom);
    wait_done(tag, data);
  endtask

  // Reference behaviour of an UP/DOWN command starting from cnt.
  function automatic exp_t model_step(input int start, input bit up, input int len);
    exp_t e;
    int   c = start;
    e.nce = 0; e.nwrap = 0; e.nsat = 0; e.nld = 0;
    for (int i = 0; i < len; i++) begin
      if (SAT_EN && (up ? (c == 15) : (c == 0))) begin
        e.nsat = 1;
        break;
      end
      if (up ? (c == 15) : (c == 0)) e.nwrap++;
      c = up ? (c + 1) % 16 : (c + 15) % 16;
      e.nce++;
    end
    e.count = c;
    e.lat   = e.nsat ? e.nce + 2 : len + 1;
    return e;
  endfunction

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_LOAD; cmd_data = '0; cmd_len = '0;

    // count, nce, lat, nwrap, nsat, nld
    vecs[0] = '{OP_LOAD,    4'd9,  8'd0, '{9, 0, 2, 0, 0, 1}};
    vecs[1] = '{OP_UP,      4'd0,  8'd3, '{12, 3, 4, 0, 0, 0}};
    vecs[2] = '{OP_LOAD,    4'd2,  8'd0, '{2, 0, 2, 0, 0, 1}};
    vecs[3] = SAT_EN ? '{OP_DOWN, 4'd0, 8'd5, '{0, 2, 4, 0, 1, 0}}
                     : '{OP_DOWN, 4'd0, 8'd5, '{13, 5, 6, 1, 0, 0}};
    vecs[4] = '{OP_LOAD,    4'd12, 8'd0, '{12, 0, 2, 0, 0, 1}};
    vecs[5] = '{OP_TO_ZERO, 4'd0,  8'd0, '{0, 12, 14, 0, 0, 0}};
    vecs[6] = '{OP_TO_ZERO, 4'd0,  8'd0, '{0, 0, 2, 0, 0, 0}};
    vecs[7] = '{OP_UP,      4'd0,  8'd0, '{0, 0, 1, 0, 0, 0}};
    vecs[8] = '{OP_LOAD,    4'd15, 8'd0, '{15, 0, 2, 0, 0, 1}};
    vecs[9] = SAT_EN ? '{OP_UP, 4'd0, 8'd2, '{15, 0, 2, 0, 1, 0}}
                     : '{OP_UP, 4'd0, 8'd2, '{1, 2, 3, 1, 0, 0}};

    repeat (3) @(negedge clk);
    chk("rst cmd_ready", int'(cmd_ready), 0);
    chk("rst load_n", int'(load_n), 1);
    chk("rst ce", int'(ce), 0);
    chk("rst up_down", int'(up_down), 0);
    chk("rst data_load", int'(data_load), 0);
    chk("rst done", int'(done), 0);
    chk("rst wrap", int'(wrap), 0);
    chk("rst sat", int'(sat), 0);
    chk("rst count_out", int'(count_out), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].len, vecs[i].e);

    for (int i = 0; i < 4; i++) begin
      logic [3:0] d;
      int         len;
      bit         up;
      exp_t       e;
      d   = 4'($urandom_range(0, 15));
      len = $urandom_range(0, 20);
      up  = 1'($urandom_range(0, 1));
      e   = '{int'(d), 0, 2, 0, 0, 1};
      run_cmd($sformatf("rnd%0d_load", i), OP_LOAD, d, 8'd0, e);
      e = model_step(int'(d), up, len);
      run_cmd($sformatf("rnd%0d_step", i), up ? OP_UP : OP_DOWN, 4'd0, 8'(len), e);
    end

    // Reset while an UP len=10 is stepping, with a new command held valid.
    begin
      int guard = 0;
      while (!cmd_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      cmd_valid = 1'b1; cmd_op = OP_UP; cmd_len = 8'd10;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort pre ce", int'(ce), 1);
      rst_n = 1'b0;
      cmd_valid = 1'b1; cmd_op = OP_UP; cmd_len = 8'd2;
      @(negedge clk);
      chk("abort ce", int'(ce), 0);
      chk("abort count_out", int'(count_out), 0);
      chk("abort done", int'(done), 0);
      chk("abort cmd_ready", int'(cmd_ready), 0);
      chk("abort state", int'(dbg_state), 0);
      @(negedge clk);
      chk("abort done2", int'(done), 0);
      rst_n = 1'b1;
      #1;
      chk("abort release ready", int'(cmd_ready), 1);
      exp_q.push_back('{2, 2, 3, 0, 0, 0});
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_done("abort_next", 4'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
